// File: rtl/drum_div_pkg.sv
// Shared constants, FSM states and helpers for the DRUM-style approximate divider.
// Imported by the normaliser, the interface and the top.
package drum_div_pkg;

  localparam int W     = 16;
  localparam int K     = 7;
  localparam int F     = 9;
  localparam int ITERS = 16;
  localparam int PW    = 4;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DIV,
    DONE
  } state_e;

  // Final right shift applied to the raw quotient.
  // Range is 0..18 because pa and pb are each 0..9.
  function automatic logic [4:0] q_shift(
    input logic [PW-1:0] pa,
    input logic [PW-1:0] pb
  );
    return 5'(F) + {1'b0, pb} - {1'b0, pa};
  endfunction

endpackage

// File: rtl/drum_div7_16_u_if.sv
// Operand/result handshake bundle for drum_div7_16_u.
// master: operand source and result sink; slave: the divider.
interface drum_div7_16_u_if;
  import drum_div_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         div_by_zero;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q,
    output div_by_zero
  );

endinterface

// File: rtl/drum_div_norm.sv
// Leading-one truncation of one operand to K bits plus its shift.
// x: operand in; s: K-bit kept mantissa; p: right shift applied.
module drum_div_norm
  import drum_div_pkg::*;
(
  input  logic [W-1:0]  x,
  output logic [K-1:0]  s,
  output logic [PW-1:0] p
);

  logic [PW-1:0] k;

  always_comb begin
    k = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) k = PW'(i);
    end
    s = x[K-1:0];
    p = '0;
    if (k > PW'(K-1)) begin
      // Keep the top K bits and force the LSB to 1
      // to centre the truncation error.
      s = K'(x >> (k - PW'(K-1))) | K'(1);
      p = k - PW'(K-1);
    end
  end

endmodule

// File: rtl/drum_div7_16_u.sv
// Approximate unsigned divider: DRUM-style truncation, then restoring divide.
// Ports: clk, rst_n, in_valid/in_ready/a/b in, out_valid/out_ready/q/div_by_zero out.
module drum_div7_16_u #(
  parameter int W = 16,
  parameter int K = 7,
  parameter int F = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         div_by_zero
);
  import drum_div_pkg::*;

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  q_q, q_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [K-1:0]  sb_q, sb_d;
  logic [PW-1:0] pa_q, pa_d;
  logic [PW-1:0] pb_q, pb_d;
  logic [K-1:0]  rem_q, rem_d;
  logic [W-1:0]  n_q, n_d;
  logic [4:0]    cnt_q, cnt_d;

  logic [K-1:0]  sa_n, sb_n;
  logic [PW-1:0] pa_n, pb_n;

  logic [K:0]    rem_sh;
  logic          ge;
  logic [4:0]    sh;
  logic [W-1:0]  q_div;

  drum_div_norm u_norm_a (
    .x (a_q),
    .s (sa_n),
    .p (pa_n)
  );

  drum_div_norm u_norm_b (
    .x (b_q),
    .s (sb_n),
    .p (pb_n)
  );

  // n_q shifts the dividend out of the top while
  // quotient bits shift in at the bottom.
  always_comb begin
    rem_sh = {rem_q, n_q[W-1]};
    ge     = rem_sh >= {1'b0, sb_q};
    sh     = q_shift(pa_q, pb_q);
    q_div  = (sh >= 5'd16) ? '0 : (n_q >> sh);
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    dz_d        = dz_q;
    a_d         = a_q;
    b_d         = b_q;
    sb_d        = sb_q;
    pa_d        = pa_q;
    pb_d        = pb_q;
    rem_d       = rem_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = NORM;
        end
      end
      NORM: begin
        if (b_q == '0) begin
          // Divide-by-zero waits one extra cycle here
          // so it lands two cycles after accept.
          if (cnt_q == '0) begin
            cnt_d = 5'd1;
          end else begin
            q_d         = '1;
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          sb_d    = sb_n;
          pa_d    = pa_n;
          pb_d    = pb_n;
          rem_d   = '0;
          n_d     = {sa_n, {F{1'b0}}};
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (cnt_q == 5'(ITERS)) begin
          q_d         = q_div;
          dz_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rem_d = ge ? K'(rem_sh - {1'b0, sb_q})
                     : rem_sh[K-1:0];
          n_d   = {n_q[W-2:0], ge};
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dz_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sb_q        <= '0;
      pa_q        <= '0;
      pb_q        <= '0;
      rem_q       <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      dz_q        <= dz_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sb_q        <= sb_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_drum_div7_16_u.sv
// Scoreboard bench for drum_div7_16_u: directed vectors,
// expected results queued at issue and checked by a monitor.
module tb_drum_div7_16_u;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   n_done;
  logic ov_prev;

  typedef struct {
    logic [15:0] q;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  drum_div7_16_u_if bus ();

  drum_div7_16_u dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .a           (bus.a),
    .b           (bus.b),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .q           (bus.q),
    .div_by_zero (bus.div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rising out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1 && !ov_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result q=%0d at cycle %0d",
                   bus.q, cyc);
        end else begin
          e = sb.pop_front();
          chk("q", 32'(bus.q), 32'(e.q));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          n_done++;
        end
      end
      ov_prev = (bus.out_valid === 1'b1);
    end
  end

  task automatic issue(input logic [15:0] av,
                       input logic [15:0] bv,
                       input logic [15:0] eq,
                       input logic        ed,
                       input int          lat);
    int n;
    exp_t e;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    e.q   = eq;
    e.dz  = ed;
    e.lat = lat;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n_done < target) begin
      chk("result_timeout", 32'(n_done), 32'(target));
    end
  endtask

  task automatic run(input logic [15:0] av,
                     input logic [15:0] bv,
                     input logic [15:0] eq,
                     input logic        ed,
                     input int          lat);
    int t;
    t = n_done + 1;
    issue(av, bv, eq, ed, lat);
    wait_done(t);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int acc;
    int n;
    checks        = 0;
    errors        = 0;
    n_done        = 0;
    ov_prev       = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    run(16'd100,   16'd7,    16'd14,    1'b0, 18);
    run(16'hFFFF,  16'd3,    16'd21674, 1'b0, 18);
    run(16'd1000,  16'd0,    16'hFFFF,  1'b1, 2);
    run(16'd5,     16'd1000, 16'd0,     1'b0, 18);
    run(16'd0,     16'd9,    16'd0,     1'b0, 18);
    run(16'd127,   16'd1,    16'd127,   1'b0, 18);
    run(16'd120,   16'd11,   16'd10,    1'b0, 18);
    run(16'hFFFF,  16'hFFFF, 16'd1,     1'b0, 18);
    run(16'd1,     16'h8000, 16'd0,     1'b0, 18);
    run(16'd50,    16'd100,  16'd0,     1'b0, 18);
    run(16'd0,     16'd0,    16'hFFFF,  1'b1, 2);

    // Back-pressure: result must hold, new operands ignored.
    bus.out_ready = 1'b0;
    t = n_done + 1;
    issue(16'd1000, 16'd10, 16'd100, 1'b0, 18);
    wait_done(t);
    bus.a        = 16'd5;
    bus.b        = 16'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_q", 32'(bus.q), 32'd100);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset at DIV iteration 8 aborts the operation.
    issue(16'd100, 16'd7, 16'd14, 1'b0, 18);
    acc = cyc;
    n = 0;
    while (cyc < acc + 8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reached_iter8", 32'(cyc), 32'(acc + 8));
    t = n_done;
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(bus.q), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_result", 32'(n_done), 32'(t));
    chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);
    run(16'd200, 16'd3, 16'd67, 1'b0, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_div7_16_u.md
DRUM_DIV7_16_U -- requirements
Module: drum_div7_16_u

Interface
REQ-001 SHALL have parameter W, default 16, operand/quotient width; only 16 is supported.
REQ-002 SHALL have parameter K, default 7, significant bits kept per operand; only 7 is supported.
REQ-003 SHALL have parameter F, default 9, fractional pre-shift of dividend; only 9 is supported.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand pair valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port a  input  16  unsigned dividend.
REQ-009 SHALL have port b  input  16  unsigned divisor.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port q  output  16  approximate unsigned quotient.
REQ-013 SHALL have port div_by_zero  output  1  qualifies q; set when b was 0.

Function
REQ-014 SHALL accept operands on a cycle where in_valid and in_ready are both 1, registering a and b.
REQ-015 SHALL implement states IDLE, NORM, DIV, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL, in NORM (1 cycle), per operand find leading-one index k; if k>6 use s={1'b1, bits[k-1:k-5], 1'b1} (7 bits) with shift p=k-6, else s=operand[6:0], p=0.
REQ-017 SHALL, in DIV, run exactly 16 restoring-division iterations, one per cycle, of N=sa<<9 (16 bits) by 7-bit sb, yielding Q0=floor(sa*512/sb).
REQ-018 SHALL, on leaving DIV, set q = Q0 >> (9 - pa + pb); shift range 0..18, shifts of 16 or more give 0.
REQ-019 SHALL produce out_valid exactly 18 cycles after the accept edge (1 NORM + 16 DIV + 1 register) when b!=0.
REQ-020 SHALL, when b==0, skip DIV, set q=16'hFFFF and div_by_zero=1, and assert out_valid 2 cycles after accept.
REQ-021 SHALL return q=0, div_by_zero=0 for a==0, b!=0.
REQ-022 SHALL hold q, div_by_zero and out_valid stable in DONE until out_ready=1, then return to IDLE the next cycle.
REQ-023 SHALL not accept new operands in the cycle out_valid/out_ready complete; next accept is no earlier than the following cycle (no overlap, one operation in flight).
REQ-024 SHALL ignore in_valid, a and b outside IDLE.
REQ-025 SHALL give exact floor(a/b) whenever a<128 and b<128.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, in_ready=0, out_valid=0, q=0, div_by_zero=0, and clear all datapath registers.
REQ-027 SHALL drive in_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-028 SHALL abort any in-flight operation on rst_n assertion; no result is emitted for it.

Structure
REQ-029 SHALL place the state enum and constants W, K, F, and the 16 DIV iteration count in shared package drum_div_pkg.
REQ-030 SHALL implement the per-operand leading-one/truncation logic (REQ-016) as combinational sub-module drum_div_norm, instantiated twice.
REQ-031 SHALL use an iteration counter and a shift register for the quotient; no combinational divider array.

Verification
REQ-032 SHALL test a=100, b=7 -> q=14, div_by_zero=0, out_valid 18 cycles after accept.
REQ-033 SHALL test a=16'hFFFF, b=3 -> q=21674 (sa=127, pa=9, shift 0).
REQ-034 SHALL test a=1000, b=0 -> q=16'hFFFF, div_by_zero=1, out_valid 2 cycles after accept.
REQ-035 SHALL test a=5, b=1000 -> q=0; a=0, b=9 -> q=0.
REQ-036 SHALL test out_ready held 0 for 10 cycles in DONE -> q stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-037 SHALL test rst_n pulsed low at DIV iteration 8 -> outputs zero immediately, no out_valid, clean accept afterward.
